// File: rtl/uart_loopback_top.sv
// UART 8N1 echo: a receiver feeds each well-framed byte to a transmitter,
// with a one-byte holding buffer between them. Single clock domain.
`timescale 1ns/1ps
module uart_loopback_top #(
  parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic uart_rx,
  output logic uart_tx
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic rx_meta, rx_sync;

  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [3:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic             rx_valid;

  tx_state_t        tx_state, tx_state_n;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
  logic [3:0]       tx_bit, tx_bit_n;
  logic [7:0]       tx_shift, tx_shift_n;
  logic             buf_full, buf_full_n;
  logic [7:0]       buf_data, buf_data_n;
  logic             uart_tx_n;

  // Synchronizer resets to the idle level so reset itself never looks like a start bit
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_valid   = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        rx_bit_n = '0;
        if (!rx_sync) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 1'b1;
          if (rx_bit == 4'd7) rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n = '0;
          if (rx_sync) begin
            rx_valid   = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            rx_state_n = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        rx_cnt_n = '0;
        if (rx_sync) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      buf_full <= 1'b0;
      buf_data <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      buf_full <= buf_full_n;
      buf_data <= buf_data_n;
      uart_tx  <= uart_tx_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    buf_full_n = buf_full;
    buf_data_n = buf_data;
    uart_tx_n  = 1'b1;
    unique case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        tx_bit_n = '0;
        // A buffered byte is older than one arriving now, so it goes first
        if (buf_full) begin
          tx_shift_n = buf_data;
          buf_full_n = 1'b0;
          tx_state_n = TX_START;
        end else if (rx_valid) begin
          tx_shift_n = rx_shift;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_bit_n   = tx_bit + 1'b1;
          if (tx_bit == 4'd7) tx_state_n = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase

    // Byte not taken directly by an idle transmitter parks in the buffer if there is room
    if (rx_valid && !(tx_state == TX_IDLE && !buf_full) && !buf_full_n) begin
      buf_full_n = 1'b1;
      buf_data_n = rx_shift;
    end

    unique case (tx_state_n)
      TX_START: uart_tx_n = 1'b0;
      TX_DATA:  uart_tx_n = tx_shift_n[0];
      default:  uart_tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_loopback_top.sv
// Directed bench for the UART echo block, run at 32 clocks per bit.
`timescale 1ns/1ps
module tb_uart_loopback_top;

  localparam int unsigned BIT = 32;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic uart_rx = 1'b0;
  logic uart_tx;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       echo;
  } vec_t;

  vec_t vecs[15];

  uart_loopback_top #(
    .CLK_FREQ_HZ(3_200_000),
    .BAUD_RATE  (100_000)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one frame starting at the current negedge; line is left idle high.
  task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge sys_clk);
    for (int unsigned i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (BIT) @(negedge sys_clk);
    end
    uart_rx = stop_bit;
    repeat (BIT) @(negedge sys_clk);
    uart_rx = 1'b1;
  endtask

  // Called right when the rx frame ends; samples 10.5 bit periods after its start edge.
  task automatic check_echo(input string tag, input logic [7:0] d);
    logic exp;
    repeat (BIT / 2) @(negedge sys_clk);
    for (int unsigned k = 0; k < 10; k++) begin
      if (k == 0)      exp = 1'b0;
      else if (k == 9) exp = 1'b1;
      else             exp = d[k-1];
      check_bit($sformatf("%s bit%0d", tag, k), uart_tx, exp);
      if (k < 9) repeat (BIT) @(negedge sys_clk);
    end
  endtask

  task automatic expect_idle(input string name, input int unsigned cycles);
    logic seen_low = 1'b0;
    repeat (cycles) begin
      @(negedge sys_clk);
      if (uart_tx !== 1'b1) seen_low = 1'b1;
    end
    check_bit(name, ~seen_low, 1'b1);
  endtask

  task automatic capture_frame(input int unsigned idx, input logic [7:0] exp);
    int unsigned waited = 0;
    logic [7:0]  got;
    while (uart_tx !== 1'b0 && waited < 40 * BIT) begin
      @(negedge sys_clk);
      waited++;
    end
    if (uart_tx !== 1'b0) begin
      check_bit($sformatf("b2b[%0d] start timeout", idx), uart_tx, 1'b0);
      return;
    end
    repeat (BIT / 2 - 1) @(negedge sys_clk);
    for (int unsigned i = 0; i < 8; i++) begin
      repeat (BIT) @(negedge sys_clk);
      got[i] = uart_tx;
    end
    check_byte($sformatf("b2b[%0d] data", idx), got, exp);
    repeat (BIT) @(negedge sys_clk);
    check_bit($sformatf("b2b[%0d] stop", idx), uart_tx, 1'b1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    string hello = "Hello, world!";
    for (int unsigned i = 0; i < 13; i++) vecs[i] = '{hello[i], 1'b1, 1'b1};
    vecs[13] = '{8'h55, 1'b0, 1'b0};
    vecs[14] = '{8'h3C, 1'b1, 1'b1};

    // Reset with the line held low: the released line is the start of 'A'
    sys_rst = 1'b1;
    uart_rx = 1'b0;
    repeat (5) @(negedge sys_clk);
    check_bit("reset uart_tx", uart_tx, 1'b1);
    sys_rst = 1'b0;
    fork
      drive_frame(8'h41, 1'b1);
      expect_idle("tx idle before first echo", 9 * BIT);
    join
    check_echo("echo A", 8'h41);

    for (int unsigned v = 0; v < 15; v++) begin
      drive_frame(vecs[v].data, vecs[v].stop_bit);
      if (vecs[v].echo) check_echo($sformatf("vec[%0d]", v), vecs[v].data);
      else              expect_idle($sformatf("vec[%0d] no echo", v), 12 * BIT);
    end

    // Short low pulse on an idle line is rejected at mid start bit
    uart_rx = 1'b0;
    repeat (5) @(negedge sys_clk);
    uart_rx = 1'b1;
    expect_idle("glitch no echo", 22 * BIT);

    // Back-to-back frames: the second and third go through the holding buffer
    fork
      begin
        drive_frame(8'h31, 1'b1);
        drive_frame(8'h32, 1'b1);
        drive_frame(8'h33, 1'b1);
      end
      begin
        capture_frame(0, 8'h31);
        capture_frame(1, 8'h32);
        capture_frame(2, 8'h33);
      end
    join
    expect_idle("idle after b2b", 4 * BIT);

    // Reset during data bit 3 of an echo (0x96: bit3 = 0)
    drive_frame(8'h96, 1'b1);
    repeat (BIT / 2) @(negedge sys_clk);
    check_bit("midrst start bit", uart_tx, 1'b0);
    repeat (4 * BIT) @(negedge sys_clk);
    check_bit("midrst data bit3", uart_tx, 1'b0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_bit("midrst tx after reset", uart_tx, 1'b1);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    expect_idle("midrst no partial byte", 12 * BIT);
    drive_frame(8'hC3, 1'b1);
    check_echo("after midrst", 8'hC3);

    repeat (BIT) @(negedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
